mux_rr_arbiter: RTL

//  Round-robin arbiter that shares one 4:1 single-bit mux between four requesters.
//  - Drives the mux Select lines and a one-hot grant back to the requesters.
//  - Holds a grant while the owner keeps requesting; forces rotation after HOLD_MAX

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, requester
// count and select width, plus a one-hot decode helper.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search over four requests: the first set bit at or after
// ptr+1 (wrapping, ptr itself checked last) wins.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one shared 4:1 mux. Grants are held while the
// owner keeps requesting, with forced rotation after HOLD_MAX cycles of contention.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       forced
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   select_q, select_d;
  logic               busy_q, busy_d;
  logic               forced_q, forced_d;

  logic [NUM_REQ-1:0] pick_req;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold_full;

  // While owning, the owner is masked so the search yields the next winner after it.
  assign pick_req  = (state_q == ST_OWN) ? (req & ~onehot(ptr_q)) : req;
  assign hold_full = (cnt_q == CNT_W'(HOLD_MAX));

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    select_d = select_q;
    busy_d   = busy_q;
    forced_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d  = ST_OWN;
          ptr_d    = pick_idx;
          cnt_d    = CNT_W'(1);
          grant_d  = onehot(pick_idx);
          select_d = pick_idx;
          busy_d   = 1'b1;
        end
      end
      ST_OWN: begin
        if (req[ptr_q]) begin
          if (pick_found && hold_full) begin
            ptr_d    = pick_idx;
            cnt_d    = CNT_W'(1);
            grant_d  = onehot(pick_idx);
            select_d = pick_idx;
            forced_d = 1'b1;
          end else if (!hold_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (pick_found) begin
          // Voluntary release, even if the hold limit was reached this cycle.
          ptr_d    = pick_idx;
          cnt_d    = CNT_W'(1);
          grant_d  = onehot(pick_idx);
          select_d = pick_idx;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'b11;
      cnt_q    <= '0;
      grant_q  <= '0;
      select_q <= 2'b00;
      busy_q   <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      forced_q <= forced_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign busy   = busy_q;
  assign forced = forced_q;

endmodule
